// File: rtl/spi_master_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl_if
// Host-side command/response bundle for spi_master_ctrl.
//
// Signals:
//   start    host -> ctrl  command request, taken only while busy is low
//   cmd      host -> ctrl  00 wr addr, 01 wr data, 10 rd addr, 11 rd data
//   data_in  host -> ctrl  address/data payload
//   busy     ctrl -> host  frame in progress (accept cycle to end of SS_N gap)
//   done     ctrl -> host  one-cycle pulse when SS_N returns high
//   rd_data  ctrl -> host  byte captured by the last read-data frame
//   rd_valid ctrl -> host  one-cycle pulse with done on read-data frames
//
// Modports: "master" is the host issuing commands, "slave" is the
// controller receiving them (the controller is still the SPI master on
// the serial side).
// ---------------------------------------------------------------------------
interface spi_master_ctrl_if;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] data_in;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (
        output start, cmd, data_in,
        input  busy, done, rd_data, rd_valid
    );

    modport slave (
        input  start, cmd, data_in,
        output busy, done, rd_data, rd_valid
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl
// Host-side SPI master for the spi_ram slave. Turns a single-cycle host
// command into an 11-bit SS_N-low frame (select bit + 2-bit cmd + 8-bit
// payload, MSB first, one bit per clk). Read-data frames then wait
// RD_LATENCY cycles and shift in an 8-bit byte from MISO, which is handed
// to the host with rd_valid.
//
// Parameters:
//   RD_LATENCY  cycles between last MOSI frame bit and first MISO bit (1-15)
//   SS_GAP      minimum SS_N-high cycles between frames (1-15)
//
// Ports:
//   clk        system clock, rising edge
//   RST        synchronous active-high reset
//   host       command/response bundle (slave modport)
//   MISO_main  serial data from slave
//   MOSI_main  serial data to slave (registered)
//   SS_N       active-low slave select (registered)
//
// State table:
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_IDLE    | waiting for start, SS_N high, busy low
//   ST_SEL     | drives the write/read select bit (cmd[1])
//   ST_SHIFT   | drives frame bits 9..0, counter 9 -> 0
//   ST_WAIT_RD | read turnaround, RD_LATENCY cycles, MOSI low
//   ST_CAPTURE | samples 8 MISO bits, MSB first
//   ST_GAP     | SS_N high for SS_GAP cycles; done/rd_valid on entry
// ---------------------------------------------------------------------------
module spi_master_ctrl #(
    parameter int RD_LATENCY = 2,
    parameter int SS_GAP     = 2
) (
    input  logic                 clk,
    input  logic                 RST,
    spi_master_ctrl_if.slave     host,
    input  logic                 MISO_main,
    output logic                 MOSI_main,
    output logic                 SS_N
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SEL     = 3'd1;
    localparam logic [2:0] ST_SHIFT   = 3'd2;
    localparam logic [2:0] ST_WAIT_RD = 3'd3;
    localparam logic [2:0] ST_CAPTURE = 3'd4;
    localparam logic [2:0] ST_GAP     = 3'd5;

    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Timers are down-counters that end on terminal count 0, so the load
    // value for an N-cycle phase is N-1. GAP loads SS_GAP (not SS_GAP-1)
    // because its first cycle also carries the done pulse, giving SS_GAP
    // busy cycles after SS_N rises.
    localparam logic [3:0] RD_LAT_LOAD = 4'(RD_LATENCY - 1);
    localparam logic [3:0] GAP_LOAD    = 4'(SS_GAP);
    localparam logic [3:0] SHIFT_LOAD  = 4'd9;
    localparam logic [3:0] CAP_LOAD    = 4'd7;

    logic [2:0] state_q,    state_d;
    logic [3:0] cnt_q,      cnt_d;
    logic [9:0] frame_q,    frame_d;
    logic [7:0] shift_q,    shift_d;
    logic       mosi_q,     mosi_d;
    logic       ss_n_q,     ss_n_d;
    logic       busy_q,     busy_d;
    logic       done_q,     done_d;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] rd_data_q,  rd_data_d;

    logic       is_rd_data;

    assign is_rd_data = (frame_q[9:8] == CMD_RD_DATA);

    // Serial outputs are registered from the current state, so they lag
    // the state register by one cycle: SEL is seen on the pins one edge
    // after the accept, and GAP's SS_N rise coincides with done.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frame_d    = frame_q;
        shift_d    = shift_q;
        rd_data_d  = rd_data_q;
        mosi_d     = 1'b0;
        ss_n_d     = 1'b1;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (host.start) begin
                    frame_d = {host.cmd,
                               (host.cmd == CMD_RD_DATA) ? 8'h00 : host.data_in};
                    state_d = ST_SEL;
                end
            end

            ST_SEL: begin
                ss_n_d  = 1'b0;
                mosi_d  = frame_q[9];
                cnt_d   = SHIFT_LOAD;
                state_d = ST_SHIFT;
            end

            ST_SHIFT: begin
                ss_n_d = 1'b0;
                mosi_d = frame_q[cnt_q];
                if (cnt_q == 4'd0) begin
                    if (is_rd_data) begin
                        cnt_d   = RD_LAT_LOAD;
                        state_d = ST_WAIT_RD;
                    end else begin
                        cnt_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_WAIT_RD: begin
                ss_n_d = 1'b0;
                if (cnt_q == 4'd0) begin
                    cnt_d   = CAP_LOAD;
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_CAPTURE: begin
                ss_n_d  = 1'b0;
                shift_d = {shift_q[6:0], MISO_main};
                if (cnt_q == 4'd0) begin
                    cnt_d   = GAP_LOAD;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_GAP: begin
                // Counter still at its load value means first GAP cycle.
                if (cnt_q == GAP_LOAD) begin
                    done_d = 1'b1;
                    if (is_rd_data) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = shift_q;
                    end
                end
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            frame_q    <= 10'd0;
            shift_q    <= 8'h00;
            mosi_q     <= 1'b0;
            ss_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            shift_q    <= shift_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign MOSI_main     = mosi_q;
    assign SS_N          = ss_n_q;
    assign host.busy     = busy_q;
    assign host.done     = done_q;
    assign host.rd_valid = rd_valid_q;
    assign host.rd_data  = rd_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_master_ctrl
// Three controller instances (RD_LATENCY 2, 1, 4) share clock and reset.
// Each frame is watched cycle by cycle after the accept edge and compared
// with the frame format, timing and a frame-level model of the RAM slave.
// ---------------------------------------------------------------------------
module tb_spi_master_ctrl;

    localparam int SS_GAP = 2;

    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    logic [2:0]       start_v, miso_v, ss_n_v, mosi_v, busy_v, done_v, rdv_v;
    logic [2:0][1:0]  cmd_v;
    logic [2:0][7:0]  din_v, rdd_v;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] last_rd [3];
    logic [7:0] ram [256];
    logic [7:0] ptr;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int RL = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        spi_master_ctrl_if hif ();
        assign hif.start   = start_v[g];
        assign hif.cmd     = cmd_v[g];
        assign hif.data_in = din_v[g];
        spi_master_ctrl #(.RD_LATENCY(RL), .SS_GAP(SS_GAP)) u_dut (
            .clk       (clk),
            .RST       (RST),
            .host      (hif),
            .MISO_main (miso_v[g]),
            .MOSI_main (mosi_v[g]),
            .SS_N      (ss_n_v[g])
        );
        assign busy_v[g] = hif.busy;
        assign done_v[g] = hif.done;
        assign rdv_v[g]  = hif.rd_valid;
        assign rdd_v[g]  = hif.rd_data;
    end

    function automatic int rl_of(input int idx);
        return (idx == 0) ? 2 : ((idx == 1) ? 1 : 4);
    endfunction

    // Runs one frame on instance idx; mb is the byte the slave returns on
    // read-data frames. guard_k > 0 pulses a second start at that cycle.
    task automatic run_frame(input int idx, input logic [1:0] c, input logic [7:0] d,
                             input logic [7:0] mb, input int guard_k, input string tag);
        int rl, exp_len, exp_done, exp_fall;
        int low_cnt, first_low, last_low, done_cnt, done_k, rdv_cnt, fall_k, idle_bad;
        logic rd;
        logic [39:0] got, exp_bits;
        logic [7:0] pay, rd_seen;
        rl = rl_of(idx);
        rd = (c == 2'b11);
        pay = rd ? 8'h00 : d;
        exp_len  = rd ? 19 + rl : 11;
        exp_done = exp_len + 1;
        exp_fall = exp_done + SS_GAP;
        exp_bits = 40'({c[1], c, pay}) << (rd ? rl + 8 : 0);
        got = '0; low_cnt = 0; first_low = -1; last_low = -1; done_cnt = 0;
        done_k = -1; rdv_cnt = 0; fall_k = -1; idle_bad = 0; rd_seen = 8'h00;

        @(negedge clk);
        start_v[idx] = 1'b1; cmd_v[idx] = c; din_v[idx] = d;
        @(posedge clk); #1;
        start_v[idx] = 1'b0; cmd_v[idx] = 2'($urandom); din_v[idx] = 8'($urandom);
        tests_run++;
        if (busy_v[idx] !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s accept_busy: got %b want 1", tag, busy_v[idx]);
        end
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k >= 12 + rl && k <= 19 + rl) miso_v[idx] = mb[7 - (k - 12 - rl)];
            else miso_v[idx] = 1'($urandom);
            if (k == guard_k) begin
                start_v[idx] = 1'b1; cmd_v[idx] = 2'b01; din_v[idx] = 8'($urandom);
            end else begin
                start_v[idx] = 1'b0;
            end
            @(posedge clk); #1;
            if (ss_n_v[idx] === 1'b0) begin
                if (first_low < 0) first_low = k;
                last_low = k;
                low_cnt++;
                got = {got[38:0], mosi_v[idx]};
            end else if (mosi_v[idx] !== 1'b0) begin
                idle_bad++;
            end
            if (done_v[idx] === 1'b1) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (rdv_v[idx] === 1'b1) begin
                rdv_cnt++;
                rd_seen = rdd_v[idx];
            end
            if (busy_v[idx] === 1'b0) begin
                fall_k = k;
                break;
            end
        end
        start_v[idx] = 1'b0;
        if (rd) last_rd[idx] = mb;

        tests_run++;
        if (fall_k != exp_fall) begin
            tests_failed++;
            $display("FAIL %s busy_fall_cycle: got %0d want %0d (-1 = timeout)", tag, fall_k, exp_fall);
        end
        tests_run++;
        if (first_low != 1 || last_low != exp_len || low_cnt != exp_len) begin
            tests_failed++;
            $display("FAIL %s ss_n_window: got first %0d last %0d count %0d want 1 %0d %0d",
                     tag, first_low, last_low, low_cnt, exp_len, exp_len);
        end
        tests_run++;
        if (got !== exp_bits) begin
            tests_failed++;
            $display("FAIL %s mosi_bits: got %h want %h", tag, got, exp_bits);
        end
        tests_run++;
        if (idle_bad != 0) begin
            tests_failed++;
            $display("FAIL %s mosi_idle: got %0d nonzero cycles want 0", tag, idle_bad);
        end
        tests_run++;
        if (done_cnt != 1 || done_k != exp_done) begin
            tests_failed++;
            $display("FAIL %s done: got %0d pulses first at %0d want 1 at %0d", tag, done_cnt, done_k, exp_done);
        end
        tests_run++;
        if (rdv_cnt != (rd ? 1 : 0)) begin
            tests_failed++;
            $display("FAIL %s rd_valid_count: got %0d want %0d", tag, rdv_cnt, rd ? 1 : 0);
        end
        if (rd) begin
            tests_run++;
            if (rd_seen !== mb) begin
                tests_failed++;
                $display("FAIL %s rd_data_at_valid: got %h want %h", tag, rd_seen, mb);
            end
        end
        tests_run++;
        if (rdd_v[idx] !== last_rd[idx]) begin
            tests_failed++;
            $display("FAIL %s rd_data_hold: got %h want %h", tag, rdd_v[idx], last_rd[idx]);
        end
    endtask

    // Frame-level model of the RAM slave on instance 0.
    task automatic ram_frame(input logic [1:0] c, input logic [7:0] d, input int guard_k, input string tag);
        logic [7:0] mb;
        mb = 8'($urandom);
        case (c)
            2'b00: ptr = d;
            2'b01: ram[ptr] = d;
            2'b10: ptr = d;
            default: mb = ram[ptr];
        endcase
        run_frame(0, c, d, mb, guard_k, tag);
    endtask

    task automatic test_reset();
        @(negedge clk);
        RST = 1'b1; start_v = 3'b111; cmd_v[0] = 2'b01; din_v[0] = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({ss_n_v[0], mosi_v[0], busy_v[0], done_v[0], rdv_v[0], rdd_v[0]} !== {5'b10000, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset_state: got ss_n %b mosi %b busy %b done %b rdv %b rdd %h want 1 0 0 0 0 00",
                     ss_n_v[0], mosi_v[0], busy_v[0], done_v[0], rdv_v[0], rdd_v[0]);
        end
        @(negedge clk);
        RST = 1'b0; start_v = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (ss_n_v !== 3'b111 || busy_v !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_no_frame: got ss_n %b busy %b want 111 000", ss_n_v, busy_v);
        end
        for (int i = 0; i < 3; i++) last_rd[i] = 8'h00;
    endtask

    task automatic test_write_address();
        ram_frame(2'b00, 8'hDD, 0, "wr_addr_dd");
    endtask

    task automatic test_round_trip();
        ram_frame(2'b00, 8'hDD, 0, "rt1_wa");
        ram_frame(2'b01, 8'hDE, 0, "rt1_wd");
        ram_frame(2'b10, 8'hDD, 0, "rt1_ra");
        ram_frame(2'b11, 8'h00, 0, "rt1_rd");
        tests_run++;
        if (rdd_v[0] !== 8'hDE) begin
            tests_failed++;
            $display("FAIL round_trip_de: got %h want DE", rdd_v[0]);
        end
        ram_frame(2'b00, 8'h3C, 0, "rt2_wa");
        ram_frame(2'b01, 8'hA5, 0, "rt2_wd");
        ram_frame(2'b10, 8'h3C, 0, "rt2_ra");
        ram_frame(2'b11, 8'h77, 0, "rt2_rd");
        tests_run++;
        if (rdd_v[0] !== 8'hA5) begin
            tests_failed++;
            $display("FAIL round_trip_a5: got %h want A5", rdd_v[0]);
        end
    endtask

    task automatic test_busy_guard();
        ram_frame(2'b10, 8'($urandom), 6, "guard_ra");
        ram_frame(2'b11, 8'($urandom), 15, "guard_rd");
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        bad = 0;
        @(negedge clk);
        start_v[0] = 1'b1; cmd_v[0] = 2'b11; din_v[0] = 8'h00;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        // 5th SHIFT cycle ends at accept+6
        repeat (5) @(posedge clk);
        @(negedge clk);
        RST = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (ss_n_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || mosi_v[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_abort: got ss_n %b busy %b mosi %b want 1 0 0", ss_n_v[0], busy_v[0], mosi_v[0]);
        end
        @(negedge clk);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) last_rd[i] = 8'h00;
        repeat (30) begin
            @(posedge clk); #1;
            if (done_v[0] !== 1'b0 || rdv_v[0] !== 1'b0 || ss_n_v[0] !== 1'b1) bad++;
        end
        tests_run++;
        if (bad != 0 || rdd_v[0] !== 8'h00) begin
            tests_failed++;
            $display("FAIL midreset_quiet: got %0d bad cycles rd_data %h want 0 00", bad, rdd_v[0]);
        end
        run_frame(0, 2'b00, 8'h10, 8'h00, 0, "midreset_wa10");
    endtask

    task automatic test_latency_sweep();
        for (int idx = 1; idx < 3; idx++) begin
            run_frame(idx, 2'b11, 8'($urandom), 8'h5A, 0, "lat_5a");
            run_frame(idx, 2'b01, 8'($urandom), 8'($urandom), 0, "lat_wd");
            run_frame(idx, 2'b11, 8'h00, 8'($urandom), 0, "lat_rand");
        end
    endtask

    task automatic test_back_to_back();
        ram_frame(2'b00, 8'h81, 0, "b2b_wa");
        ram_frame(2'b01, 8'h42, 0, "b2b_wd");
        ram_frame(2'b11, 8'h00, 0, "b2b_rd");
        ram_frame(2'b11, 8'h00, 0, "b2b_rd2");
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            int idx;
            idx = int'($urandom_range(0, 2));
            if (idx == 0) ram_frame(2'($urandom), 8'($urandom), 0, "rand_ram");
            else run_frame(idx, 2'($urandom), 8'($urandom), 8'($urandom), 0, "rand_lat");
        end
    endtask

    initial begin
        RST = 1'b1;
        start_v = '0; miso_v = '0; cmd_v = '0; din_v = '0;
        ptr = 8'h00;
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) last_rd[i] = 8'h00;
        test_reset();
        test_write_address();
        test_round_trip();
        test_busy_guard();
        test_reset_mid_frame();
        test_latency_sweep();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
